// File: rtl/bin2bcd8.sv
// bin2bcd8: 8-bit unsigned binary to three-digit BCD converter.
// Combinational double dabble (shift-add-3) core feeding a one-cycle
// output register. Digits reset to 0/0/0, which is a legal BCD value.

module bin2bcd8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] bin,
    output logic       out_valid,
    output logic [3:0] centaines,
    output logic [3:0] dizaines,
    output logic [3:0] unites
);

    // Packed BCD result of the combinational core: {hundreds, tens, units}.
    logic [11:0] bcd_next;

    // Double dabble over 8 shift steps: correct each nibble that would
    // overflow a decimal digit after doubling, then shift the next bin bit in.
    always_comb begin
        logic [11:0] scratch;
        logic [7:0]  bits;
        scratch = '0;
        bits    = bin;
        for (int step = 0; step < 8; step++) begin
            for (int nib = 0; nib < 3; nib++) begin
                if (scratch[nib*4 +: 4] >= 4'd5) begin
                    scratch[nib*4 +: 4] = scratch[nib*4 +: 4] + 4'd3;
                end
            end
            scratch = {scratch[10:0], bits[7]};
            bits    = {bits[6:0], 1'b0};
        end
        bcd_next = scratch;
    end

    // Output register: capture on in_valid, otherwise hold digits and
    // drop out_valid. Reset takes priority and discards any capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            centaines <= 4'd0;
            dizaines  <= 4'd0;
            unites    <= 4'd0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            centaines <= bcd_next[11:8];
            dizaines  <= bcd_next[7:4];
            unites    <= bcd_next[3:0];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin2bcd8.sv
// tb_bin2bcd8: directed self-checking bench for bin2bcd8.
// Each check compares {out_valid, centaines, dizaines, unites} one cycle
// after the inputs were presented; expected BCD values are written as hex
// literals (e.g. 12'h255 means 2/5/5).

module tb_bin2bcd8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] bin;
    logic       out_valid;
    logic [3:0] centaines;
    logic [3:0] dizaines;
    logic [3:0] unites;

    int n_checks;
    int n_fail;

    bin2bcd8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .bin       (bin),
        .out_valid (out_valid),
        .centaines (centaines),
        .dizaines  (dizaines),
        .unites    (unites)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare observed {out_valid, digits} with the expected value.
    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {out_valid, centaines, dizaines, unites};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed v=%b %h/%h/%h expected v=%b %h/%h/%h",
                   tag, obs[12], obs[11:8], obs[7:4], obs[3:0],
                   exp[12], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    logic [7:0]  dir_bin [7];
    logic [11:0] dir_exp [7];
    logic [3:0]  eh, et, eu;

    // Directed sequence: reset, boundary captures, full sweep, hold,
    // mid-stream reset and alternating back-to-back values.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        dir_bin  = '{8'd0, 8'd1, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
        dir_exp  = '{12'h000, 12'h001, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};

        // 1. Reset wins over in_valid with bin=255.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        bin      = 8'd255;
        cyc();
        chk("reset_c1", {1'b0, 12'h000});
        cyc();
        chk("reset_c2", {1'b0, 12'h000});

        // 2. Directed boundary captures, one per cycle.
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bin = dir_bin[i];
            cyc();
            chk($sformatf("directed_%0d", dir_bin[i]), {1'b1, dir_exp[i]});
        end

        // 3. Exhaustive sweep with in_valid held high.
        for (int v = 0; v < 256; v++) begin
            bin = 8'(v);
            eh  = 4'(v / 100);
            et  = 4'((v / 10) % 10);
            eu  = 4'(v % 10);
            cyc();
            chk($sformatf("sweep_%0d", v), {1'b1, eh, et, eu});
        end

        // 4. Capture 173, then hold with random bin and in_valid low.
        bin = 8'd173;
        cyc();
        chk("hold_capture", {1'b1, 12'h173});
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bin = 8'($urandom);
            cyc();
            chk($sformatf("hold_%0d", i), {1'b0, 12'h173});
        end

        // 5. Mid-stream reset on the 201 cycle.
        in_valid = 1'b1;
        bin      = 8'd200;
        cyc();
        chk("mid_200", {1'b1, 12'h200});
        bin   = 8'd201;
        rst_n = 1'b0;
        cyc();
        chk("mid_reset", {1'b0, 12'h000});
        bin   = 8'd202;
        rst_n = 1'b1;
        cyc();
        chk("mid_202", {1'b1, 12'h202});

        // 6. Alternate 99 and 100 every cycle, no bubbles.
        for (int k = 0; k < 8; k++) begin
            bin = (k % 2 == 0) ? 8'd99 : 8'd100;
            cyc();
            chk($sformatf("alt_%0d", k), (k % 2 == 0) ? {1'b1, 12'h099} : {1'b1, 12'h100});
        end

        // Dropping in_valid after a stream clears out_valid, digits hold.
        in_valid = 1'b0;
        cyc();
        chk("alt_drop", {1'b0, 12'h100});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
